// File: rtl/fv_rvc_fetch_aligner_if.sv
// Handshake bundle between the fetch unit, the RVC fetch aligner and the instruction decoders.
// master = environment side (fetch source and decoder sink), slave = aligner side.
interface fv_rvc_fetch_aligner_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_data;
  logic [XLEN-1:0] fetch_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_is_rvc;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, fetch_pc, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_pc, instr_is_rvc
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, fetch_pc, instr_ready,
    output fetch_ready, instr_valid, instr, instr_pc, instr_is_rvc
  );
endinterface

// File: rtl/fv_rvc_fetch_aligner.sv
// Halfword realigner between the fetch unit and the RVC/RV32 decoders. Aligned fetch words are
// split into a small halfword queue and one 16- or 32-bit instruction is offered per handshake
// from the queue head, including 32-bit instructions that straddle two fetch words.
module fv_rvc_fetch_aligner #(
  parameter int XLEN     = 32,
  parameter int HQ_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fv_rvc_fetch_aligner_if.slave bus
);
  localparam int CW = $clog2(HQ_DEPTH + 1);
  localparam int IW = $clog2(HQ_DEPTH);
  localparam logic [XLEN-1:0] PC_INC2 = {{(XLEN-3){1'b0}}, 3'd2};
  localparam logic [XLEN-1:0] PC_INC4 = {{(XLEN-3){1'b0}}, 3'd4};

  logic [15:0]     q_r [HQ_DEPTH];
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] head_pc_r;
  logic            skip_lo_r;
  logic            pc_anchor_r;  // head PC came from a redirect; the next fetch word must not replace it

  logic [15:0]     q_n_s [HQ_DEPTH];
  logic [CW-1:0]   count_n_s;
  logic [XLEN-1:0] base_pc_s;
  logic [XLEN-1:0] head_pc_n_s;
  logic [15:0]     push_hw_s [2];
  logic            head_rvc_s;
  logic            fetch_ready_s;
  logic            instr_valid_s;
  logic            push_s;
  logic            pop_s;
  int              count_i_s;
  int              push_cnt_s;
  int              pop_cnt_s;
  logic            unused_ok_s;

  assign count_i_s     = int'(count_r);
  assign head_rvc_s    = (q_r[0][1:0] != 2'b11);
  assign fetch_ready_s = rst_n && !bus.flush && (count_i_s <= HQ_DEPTH - 32'sd2);
  assign instr_valid_s = rst_n && !bus.flush &&
                         ((count_i_s >= 32'sd1 && head_rvc_s) || (count_i_s >= 32'sd2 && !head_rvc_s));
  assign push_s        = bus.fetch_valid && fetch_ready_s;
  assign pop_s         = instr_valid_s && bus.instr_ready;
  // Address bits below halfword/word granularity carry no information here.
  assign unused_ok_s   = ^{bus.fetch_pc[1:0], bus.flush_pc[0]};

  // Halfword counts moved this cycle and the halfwords a push appends (upper half only after a mid-word redirect).
  always_comb begin
    push_hw_s[0] = bus.fetch_data[15:0];
    push_hw_s[1] = bus.fetch_data[31:16];
    push_cnt_s   = 32'sd0;
    pop_cnt_s    = 32'sd0;
    if (skip_lo_r) begin
      push_hw_s[0] = bus.fetch_data[31:16];
    end else begin
      push_hw_s[0] = bus.fetch_data[15:0];
    end
    if (push_s) begin
      push_cnt_s = skip_lo_r ? 32'sd1 : 32'sd2;
    end else begin
      push_cnt_s = 32'sd0;
    end
    if (pop_s) begin
      pop_cnt_s = head_rvc_s ? 32'sd1 : 32'sd2;
    end else begin
      pop_cnt_s = 32'sd0;
    end
  end

  // Shift out popped halfwords and append pushed ones behind the surviving entries.
  always_comb begin
    for (int i = 0; i < HQ_DEPTH; i++) begin
      q_n_s[i] = q_r[i];
      if (i + pop_cnt_s < count_i_s) begin
        q_n_s[i] = q_r[IW'(i + pop_cnt_s)];
      end else if (i + pop_cnt_s - count_i_s < push_cnt_s) begin
        q_n_s[i] = push_hw_s[(i + pop_cnt_s - count_i_s) != 32'sd0];
      end else begin
        q_n_s[i] = q_r[i];
      end
    end
  end

  // Next count and head PC; a word entering an empty queue supplies the PC unless a redirect already did.
  always_comb begin
    count_n_s = CW'(count_i_s + push_cnt_s - pop_cnt_s);
    base_pc_s = head_pc_r;
    if (push_s && (count_r == '0) && !skip_lo_r && !pc_anchor_r) begin
      base_pc_s = {bus.fetch_pc[XLEN-1:2], 2'b00};
    end else begin
      base_pc_s = head_pc_r;
    end
    if (pop_s) begin
      head_pc_n_s = base_pc_s + (head_rvc_s ? PC_INC2 : PC_INC4);
    end else begin
      head_pc_n_s = base_pc_s;
    end
  end

  // State update: reset first, then redirect, then the normal push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r     <= '0;
      head_pc_r   <= '0;
      skip_lo_r   <= 1'b0;
      pc_anchor_r <= 1'b0;
      for (int i = 0; i < HQ_DEPTH; i++) begin
        q_r[i] <= 16'h0000;
      end
    end else if (bus.flush) begin
      count_r     <= '0;
      head_pc_r   <= {bus.flush_pc[XLEN-1:1], 1'b0};
      skip_lo_r   <= bus.flush_pc[1];
      pc_anchor_r <= 1'b1;
    end else begin
      count_r   <= count_n_s;
      head_pc_r <= head_pc_n_s;
      for (int i = 0; i < HQ_DEPTH; i++) begin
        q_r[i] <= q_n_s[i];
      end
      if (push_s) begin
        skip_lo_r   <= 1'b0;
        pc_anchor_r <= 1'b0;
      end else begin
        skip_lo_r   <= skip_lo_r;
        pc_anchor_r <= pc_anchor_r;
      end
    end
  end

  assign bus.fetch_ready  = fetch_ready_s;
  assign bus.instr_valid  = instr_valid_s;
  assign bus.instr        = !rst_n ? 32'h0000_0000 :
                            (head_rvc_s ? {16'h0000, q_r[0]} : {q_r[1], q_r[0]});
  assign bus.instr_pc     = rst_n ? head_pc_r : '0;
  assign bus.instr_is_rvc = rst_n && head_rvc_s;

  fv_rvc_fetch_aligner_chk #(
    .XLEN     (XLEN),
    .HQ_DEPTH (HQ_DEPTH),
    .CW       (CW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (bus.flush),
    .flush_word  (bus.flush_pc[XLEN-1:2]),
    .push        (push_s),
    .fetch_word  (bus.fetch_pc[XLEN-1:2]),
    .count       (count_r),
    .instr_valid (instr_valid_s),
    .head_rvc    (head_rvc_s)
  );
endmodule

// Invariant checker: queue occupancy bounds and the sequential-fetch contract with upstream.
module fv_rvc_fetch_aligner_chk #(
  parameter int XLEN     = 32,
  parameter int HQ_DEPTH = 4,
  parameter int CW       = 3
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  input logic [XLEN-3:0] flush_word,
  input logic            push,
  input logic [XLEN-3:0] fetch_word,
  input logic [CW-1:0]   count,
  input logic            instr_valid,
  input logic            head_rvc
);
  logic [XLEN-3:0] exp_word_r;
  logic            exp_valid_r;

  // Track the word address upstream is expected to deliver next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_valid_r <= 1'b0;
      exp_word_r  <= '0;
    end else if (flush) begin
      exp_valid_r <= 1'b1;
      exp_word_r  <= flush_word;
    end else if (push) begin
      exp_valid_r <= 1'b1;
      exp_word_r  <= fetch_word + {{(XLEN-3){1'b0}}, 1'b1};
    end else begin
      exp_valid_r <= exp_valid_r;
      exp_word_r  <= exp_word_r;
    end
  end

  // Occupancy, overflow, head sufficiency and fetch ordering.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_count_bound: assert (int'(count) <= HQ_DEPTH);
      a_no_overflow: assert (!push || (int'(count) <= HQ_DEPTH - 32'sd2));
      a_head_full:   assert (!instr_valid || (int'(count) >= (head_rvc ? 32'sd1 : 32'sd2)));
      if (push && exp_valid_r) begin
        a_fetch_order: assert (fetch_word == exp_word_r);
      end
    end
  end
endmodule

// File: tb/tb_fv_rvc_fetch_aligner.sv
// Self-checking bench for fv_rvc_fetch_aligner: directed scenarios plus a randomized run
// checked against a halfword-queue reference model.
module tb_fv_rvc_fetch_aligner;
  localparam int XLEN = 32;
  localparam int HQ   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fv_rvc_fetch_aligner_if #(.XLEN(XLEN)) bus ();

  fv_rvc_fetch_aligner #(.XLEN(XLEN), .HQ_DEPTH(HQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.flush       = 1'b0;
    bus.flush_pc    = 32'h0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 32'h0;
    bus.fetch_pc    = 32'h0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_0001;
    next_cycle();
    next_cycle();
    #2;
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL rst_fetch_ready got %b exp 0", bus.fetch_ready); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b exp 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", bus.instr_pc); end
    checks++; if (bus.instr_is_rvc !== 1'b0) begin errors++; $display("FAIL rst_is_rvc got %b exp 0", bus.instr_is_rvc); end
    rst_n = 1'b1;
    bus.fetch_valid = 1'b0;
    #2;
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL rel_fetch_ready got %b exp 1", bus.fetch_ready); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rel_instr_valid got %b exp 0", bus.instr_valid); end
    next_cycle();
  endtask

  task automatic test_two_rvc();
    do_reset();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_0001;
    bus.fetch_pc    = 32'h0;
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0001 || bus.instr_pc !== 32'h0 || bus.instr_is_rvc !== 1'b1)
      begin errors++; $display("FAIL rvc0 got v%b %h @%h r%b exp v1 00000001 @0 r1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0001 || bus.instr_pc !== 32'h2 || bus.instr_is_rvc !== 1'b1)
      begin errors++; $display("FAIL rvc1 got v%b %h @%h r%b exp v1 00000001 @2 r1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rvc_drained got %b exp 0", bus.instr_valid); end
    idle();
  endtask

  task automatic test_rv32();
    do_reset();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0000_0013;
    bus.fetch_pc    = 32'h0;
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h0 || bus.instr_is_rvc !== 1'b0)
      begin errors++; $display("FAIL rv32 got v%b %h @%h r%b exp v1 00000013 @0 r0", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 32'h4)
      begin errors++; $display("FAIL rv32_after got v%b @%h exp v0 @4", bus.instr_valid, bus.instr_pc); end
    idle();
  endtask

  task automatic test_straddle();
    do_reset();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0013_0001;
    bus.fetch_pc    = 32'h0;
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1 || bus.instr_pc !== 32'h0)
      begin errors++; $display("FAIL strad_rvc got v%b %h @%h exp v1 00000001 @0", bus.instr_valid, bus.instr, bus.instr_pc); end
    next_cycle();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'hABCD_0000;
    bus.fetch_pc    = 32'h4;
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.instr_pc !== 32'h2)
      begin errors++; $display("FAIL strad_wait got v%b rdy%b @%h exp v0 rdy1 @2", bus.instr_valid, bus.fetch_ready, bus.instr_pc); end
    next_cycle();
    bus.fetch_valid = 1'b0;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h2 || bus.instr_is_rvc !== 1'b0)
      begin errors++; $display("FAIL strad_32 got v%b %h @%h r%b exp v1 00000013 @2 r0", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hABCD || bus.instr_pc !== 32'h6 || bus.instr_is_rvc !== 1'b1)
      begin errors++; $display("FAIL strad_tail got v%b %h @%h r%b exp v1 0000abcd @6 r1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_0001;
    bus.fetch_pc    = 32'h0;
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    bus.flush       = 1'b1;
    bus.flush_pc    = 32'h102;
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b0)
      begin errors++; $display("FAIL flush_cycle got v%b rdy%b exp v0 rdy0", bus.instr_valid, bus.fetch_ready); end
    next_cycle();
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_0013;
    bus.fetch_pc    = 32'h100;
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.instr_pc !== 32'h102)
      begin errors++; $display("FAIL flush_empty got v%b rdy%b @%h exp v0 rdy1 @102", bus.instr_valid, bus.fetch_ready, bus.instr_pc); end
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1 || bus.instr_pc !== 32'h102 || bus.instr_is_rvc !== 1'b1)
      begin errors++; $display("FAIL flush_skip got v%b %h @%h r%b exp v1 00000001 @102 r1", bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_is_rvc); end
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 32'h104)
      begin errors++; $display("FAIL flush_drain got v%b @%h exp v0 @104", bus.instr_valid, bus.instr_pc); end
    bus.instr_ready = 1'b0;
    bus.flush       = 1'b1;
    bus.flush_pc    = 32'h200;
    next_cycle();
    bus.flush_pc    = 32'h307;
    next_cycle();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0005_0013;
    bus.fetch_pc    = 32'h304;
    next_cycle();
    bus.fetch_valid = 1'b0;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h5 || bus.instr_pc !== 32'h306)
      begin errors++; $display("FAIL flush_last_wins got v%b %h @%h exp v1 00000005 @306", bus.instr_valid, bus.instr, bus.instr_pc); end
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] words [3];
    logic [15:0] exp_hw [4];
    int idx;
    words[0] = 32'h0005_0001; words[1] = 32'h0009_0011; words[2] = 32'hDEAD_0003;
    exp_hw[0] = 16'h0001; exp_hw[1] = 16'h0005; exp_hw[2] = 16'h0011; exp_hw[3] = 16'h0009;
    idx = 0;
    do_reset();
    bus.fetch_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.fetch_data = words[idx];
      bus.fetch_pc   = 32'(idx * 4);
      #2;
      checks++; if (bus.fetch_ready !== (c < 2))
        begin errors++; $display("FAIL bp_ready c%0d got %b exp %b", c, bus.fetch_ready, (c < 2)); end
      checks++; if (bus.instr_valid !== (c >= 1) || (c >= 1 && (bus.instr !== 32'h1 || bus.instr_pc !== 32'h0)))
        begin errors++; $display("FAIL bp_hold c%0d got v%b %h @%h exp v%b 00000001 @0", c, bus.instr_valid, bus.instr, bus.instr_pc, (c >= 1)); end
      if (c < 2) idx++;
      next_cycle();
    end
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== {16'h0, exp_hw[k]} || bus.instr_pc !== 32'(2 * k))
        begin errors++; $display("FAIL bp_drain k%0d got v%b %h @%h exp v1 %h @%h", k, bus.instr_valid, bus.instr, bus.instr_pc, exp_hw[k], 2 * k); end
      next_cycle();
    end
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b1)
      begin errors++; $display("FAIL bp_empty got v%b rdy%b exp v0 rdy1", bus.instr_valid, bus.fetch_ready); end
    idle();
  endtask

  task automatic test_reset_mid_straddle();
    do_reset();
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0013_0001;
    bus.fetch_pc    = 32'h0;
    next_cycle();
    bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b1)
      begin errors++; $display("FAIL mid_strad got v%b rdy%b exp v0 rdy1", bus.instr_valid, bus.fetch_ready); end
    rst_n = 1'b0;
    next_cycle();
    #2;
    checks++; if (bus.instr_valid !== 1'b0 || bus.fetch_ready !== 1'b0 || bus.instr !== 32'h0)
      begin errors++; $display("FAIL mid_rst got v%b rdy%b %h exp v0 rdy0 0", bus.instr_valid, bus.fetch_ready, bus.instr); end
    rst_n = 1'b1;
    bus.instr_ready = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0001_0001;
    bus.fetch_pc    = 32'h40;
    #2;
    checks++; if (bus.fetch_ready !== 1'b1 || bus.instr_valid !== 1'b0)
      begin errors++; $display("FAIL mid_release got rdy%b v%b exp rdy1 v0", bus.fetch_ready, bus.instr_valid); end
    next_cycle();
    bus.fetch_valid = 1'b0;
    #2;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1 || bus.instr_pc !== 32'h40)
      begin errors++; $display("FAIL mid_fresh got v%b %h @%h exp v1 00000001 @40", bus.instr_valid, bus.instr, bus.instr_pc); end
    idle();
  endtask

  task automatic test_random();
    logic [15:0] hq [$];
    logic [31:0] m_pc, next_word, data;
    logic        m_skip, m_anchor, e_rvc, e_valid, e_ready, empty_before;
    logic [31:0] e_instr;
    do_reset();
    hq.delete();
    m_pc = 32'h0; m_skip = 1'b0; m_anchor = 1'b0; next_word = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      bus.flush    = ($urandom_range(15) == 0);
      bus.flush_pc = $urandom;
      data = $urandom;
      if ($urandom_range(1) == 1) data[1:0] = 2'b11;
      if ($urandom_range(1) == 1) data[17:16] = 2'b11;
      bus.fetch_valid = ($urandom_range(3) != 0);
      bus.fetch_data  = data;
      bus.fetch_pc    = next_word | 32'($urandom_range(3));
      bus.instr_ready = ($urandom_range(3) != 0);
      #2;
      e_rvc   = (hq.size() > 0) && (hq[0][1:0] != 2'b11);
      e_valid = !bus.flush && ((hq.size() >= 1 && e_rvc) || (hq.size() >= 2 && !e_rvc));
      e_ready = !bus.flush && (hq.size() <= HQ - 2);
      e_instr = e_rvc ? {16'h0, hq[0]} : ((hq.size() >= 2) ? {hq[1], hq[0]} : 32'h0);
      checks++; if (bus.fetch_ready !== e_ready)
        begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.fetch_ready, e_ready); end
      checks++; if (bus.instr_valid !== e_valid)
        begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, bus.instr_valid, e_valid); end
      checks++; if (bus.instr_pc !== m_pc)
        begin errors++; $display("FAIL rnd_pc c%0d got %h exp %h", c, bus.instr_pc, m_pc); end
      if (e_valid) begin
        checks++; if (bus.instr !== e_instr || bus.instr_is_rvc !== e_rvc)
          begin errors++; $display("FAIL rnd_instr c%0d got %h r%b exp %h r%b", c, bus.instr, bus.instr_is_rvc, e_instr, e_rvc); end
      end
      if (bus.flush) begin
        hq.delete();
        m_pc      = {bus.flush_pc[31:1], 1'b0};
        m_skip    = bus.flush_pc[1];
        m_anchor  = 1'b1;
        next_word = {bus.flush_pc[31:2], 2'b00};
      end else begin
        empty_before = (hq.size() == 0);
        if (e_valid && bus.instr_ready) begin
          void'(hq.pop_front());
          if (!e_rvc) void'(hq.pop_front());
          m_pc = m_pc + (e_rvc ? 32'd2 : 32'd4);
        end
        if (bus.fetch_valid && e_ready) begin
          if (empty_before && !m_skip && !m_anchor) m_pc = next_word;
          if (!m_skip) hq.push_back(data[15:0]);
          hq.push_back(data[31:16]);
          m_skip    = 1'b0;
          m_anchor  = 1'b0;
          next_word = next_word + 32'd4;
        end
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_two_rvc();
    test_rv32();
    test_straddle();
    test_flush();
    test_backpressure();
    test_reset_mid_straddle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
